pipe_lock_unit: RTL and testbench
=================================

# pipe_lock_unit

Hazard and stall controller for the front of the pipeline. Each cycle it decides whether IF_ID captures a new fetch word (`locker`), holds the PC loader, inserts a bubble into DEC_ALU, or flushes on a taken branch. It generates the ALU-forward select that IF_ID pipelines into DEC_ALU. A small FSM with a down-counter stretches stalls over multi-cycle load latency, instruction-cache misses and branch-flush windows.

## Interface
- LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (legal 1..15)
- FLUSH_CYCLES, 1, total bubble cycles per taken branch (legal 1..15)
- clk  in  1  pipeline clock, all state on rising edge
- resetIn  in  1  reset; synchronous and active-high
- rs1In, rs2In  in  5  source registers of the instruction in IF_ID
- rs1UseIn, rs2UseIn  in  1  the instruction actually reads rs1 / rs2
- exRdIn  in  5  destination register of the instruction in DEC_ALU
- exRegWriteIn  in  1  the DEC_ALU instruction writes exRdIn
- exMemReadIn  in  1  the DEC_ALU instruction is a load
- branchTakenIn  in  1  branchUnit redirect this cycle
- icacheReadyIn  in  1  inst cache word valid this cycle
- locker  out  1  1 = IF_ID captures dataIn; 0 = IF_ID holds
- pcHoldOut  out  1  PC loader holds the current PC
- bubbleOut  out  1  DEC_ALU injects a NOP
- flushOut  out  1  discard IF_ID contents (redirect)
- ALUForwardCSLFromLock  out  1  forward the ALU result to the IF_ID instruction
- stateOut  out  2  current FSM state (debug)

## Operation
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MISS=3. `cnt` is a 4-bit down-counter.
- Hazard `hz` = exMemReadIn & exRegWriteIn & exRdIn!=0 & ((rs1UseIn & rs1In==exRdIn) | (rs2UseIn & rs2In==exRdIn)).
- Priority within any state: resetIn > branchTakenIn > hz > !icacheReadyIn.
- In RUN, with no event: locker=1, pcHold=0, bubble=0, flush=0. State stays RUN.
- In RUN with branchTakenIn:
  - Outputs: flush=1, bubble=1, locker=1, pcHold=0.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
- In RUN with hz:
  - Outputs: locker=0, pcHold=1, bubble=1.
  - If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-2. Otherwise stay in RUN.
- In RUN with !icacheReadyIn: outputs locker=0, pcHold=1, bubble=1. Go to MISS.
- LOAD_STALL: outputs as for a hz stall. If cnt==0, go to RUN; otherwise decrement cnt.
- FLUSH: outputs flush=1, bubble=1, locker=1, pcHold=0. If cnt==0, go to RUN; otherwise decrement cnt.
- MISS:
  - While icacheReadyIn=0: stall outputs.
  - On the cycle icacheReadyIn=1: RUN outputs (locker=1), and next state is RUN.
- branchTakenIn in LOAD_STALL or MISS aborts that state and behaves exactly as the RUN branch case.
- hz seen in MISS is served first as a load stall.
- ALUForwardCSLFromLock = exRegWriteIn & !exMemReadIn & exRdIn!=0 & an rs match. It is forced to 0 whenever bubbleOut=1.

## Timing
- All outputs are combinational from the current state and inputs (Mealy). State and cnt update on the rising edge of clk.
- A hazard or miss stalls in the same cycle it is detected. A load-use hazard costs exactly LOAD_STALL_CYCLES bubbles.
- Reset: while resetIn=1, outputs are locker=1, pcHold=0, bubble=1, flush=1, ALUForwardCSLFromLock=0, stateOut=0.
- After the edge with resetIn=1: state=RUN, cnt=0.
- resetIn asserted mid-stall or mid-flush aborts it at the next edge.
- cnt never wraps. Each counting state exits at 0.

## Configuration
- LOCK_PERF_CNT_EN defined adds two outputs:
  - stallCountOut (32): counts cycles with pcHoldOut=1.
  - flushCountOut (32): counts cycles where branchTakenIn is accepted.
  - Both saturate at 0xFFFFFFFF and are cleared by resetIn.
- LOCK_PERF_CNT_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset held for 2 cycles, then released with icacheReadyIn=1 and no hazard -> locker=1, bubble=0, stateOut=0 from the first post-reset cycle.
- Load-use hazard with LOAD_STALL_CYCLES=3: exMemReadIn=1, exRdIn=5, rs1In=5, rs1UseIn=1 -> exactly 3 consecutive cycles of locker=0, pcHold=1, bubble=1, then RUN.
- ALU hazard: exRegWriteIn=1, exMemReadIn=0, exRdIn=7, rs2In=7, rs2UseIn=1 -> ALUForwardCSLFromLock=1 with no stall. The same with exRdIn=0 -> 0.
- icacheReadyIn low for 4 cycles -> 4 stall cycles in MISS. locker=1 on the cycle ready returns.
- branchTakenIn during the 2nd cycle of a MISS, with FLUSH_CYCLES=2 -> flush=1 for 2 cycles, then RUN. With LOCK_PERF_CNT_EN: stallCountOut=1, flushCountOut=1.
- resetIn pulsed in the middle of a LOAD_STALL -> state=RUN, cnt=0 after that edge. Performance counters read 0.

Source files
------------

// File: rtl/pipe_lock_unit.sv
// Front-end hazard/stall controller: load-use stalls, I-cache miss stalls and
// branch flush windows. Optional perf counters are enabled by LOCK_PERF_CNT_EN.
module pipe_lock_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       resetIn,
  input  logic [4:0] rs1In,
  input  logic [4:0] rs2In,
  input  logic       rs1UseIn,
  input  logic       rs2UseIn,
  input  logic [4:0] exRdIn,
  input  logic       exRegWriteIn,
  input  logic       exMemReadIn,
  input  logic       branchTakenIn,
  input  logic       icacheReadyIn,
  output logic       locker,
  output logic       pcHoldOut,
  output logic       bubbleOut,
  output logic       flushOut,
  output logic       ALUForwardCSLFromLock,
`ifdef LOCK_PERF_CNT_EN
  output logic [31:0] stallCountOut,
  output logic [31:0] flushCountOut,
`endif
  output logic [1:0] stateOut
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MISS       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACT_RUN   = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } action_t;

  // The first stall/flush cycle happens in RUN (or MISS), so the counting
  // state only has to cover the remaining N-1 cycles, exiting at cnt==0.
  localparam bit       LOAD_MULTI   = (LOAD_STALL_CYCLES > 1);
  localparam bit       FLUSH_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [3:0] LOAD_RELOAD  = LOAD_MULTI  ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] FLUSH_RELOAD = FLUSH_MULTI ? 4'(FLUSH_CYCLES - 2)      : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  action_t    act;
  logic       branch_accept;

  logic [4:0] rs_addr [2];
  logic [1:0] rs_use;
  logic [1:0] rs_match_vec;
  logic       rs_match;
  logic       rd_nz;
  logic       hz;
  logic       fwd_cand;

  assign rs_addr[0] = rs1In;
  assign rs_addr[1] = rs2In;
  assign rs_use     = {rs2UseIn, rs1UseIn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs_match
      assign rs_match_vec[gi] = rs_use[gi] && (rs_addr[gi] == exRdIn);
    end
  endgenerate

  assign rs_match = |rs_match_vec;
  assign rd_nz    = (exRdIn != 5'd0);
  assign hz       = exMemReadIn & exRegWriteIn & rd_nz & rs_match;
  assign fwd_cand = exRegWriteIn & ~exMemReadIn & rd_nz & rs_match;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    act           = ACT_RUN;
    branch_accept = 1'b0;

    if (resetIn) begin
      state_d = ST_RUN;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_RUN, ST_MISS: begin
          if (branchTakenIn) begin
            act           = ACT_FLUSH;
            branch_accept = 1'b1;
            state_d       = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            cnt_d         = FLUSH_RELOAD;
          end else if (hz) begin
            // A hazard seen while waiting on the cache is served first.
            act     = ACT_STALL;
            state_d = LOAD_MULTI ? ST_LOAD_STALL : ST_RUN;
            cnt_d   = LOAD_RELOAD;
          end else if (!icacheReadyIn) begin
            act     = ACT_STALL;
            state_d = ST_MISS;
            cnt_d   = 4'd0;
          end else begin
            act     = ACT_RUN;
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end
        end

        ST_LOAD_STALL: begin
          if (branchTakenIn) begin
            act           = ACT_FLUSH;
            branch_accept = 1'b1;
            state_d       = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            cnt_d         = FLUSH_RELOAD;
          end else begin
            act = ACT_STALL;
            if (cnt_q == 4'd0) begin
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end

        ST_FLUSH: begin
          // A fresh redirect inside a flush window restarts the window.
          if (branchTakenIn) begin
            act           = ACT_FLUSH;
            branch_accept = 1'b1;
            state_d       = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            cnt_d         = FLUSH_RELOAD;
          end else begin
            act = ACT_FLUSH;
            if (cnt_q == 4'd0) begin
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end

        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    if (resetIn) begin
      locker    = 1'b1;
      pcHoldOut = 1'b0;
      bubbleOut = 1'b1;
      flushOut  = 1'b1;
    end else begin
      locker    = (act != ACT_STALL);
      pcHoldOut = (act == ACT_STALL);
      bubbleOut = (act != ACT_RUN);
      flushOut  = (act == ACT_FLUSH);
    end
    ALUForwardCSLFromLock = fwd_cand & ~bubbleOut;
    stateOut              = resetIn ? 2'd0 : state_q;
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LOCK_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pcHoldOut && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (branch_accept && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCountOut = stall_cnt_q;
  assign flushCountOut = flush_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = branch_accept;
`endif

endmodule

// File: tb/tb_pipe_lock_unit.sv
// Self-checking bench for pipe_lock_unit: directed scenarios plus a random
// run against a remaining-cycles reference model.
module tb_pipe_lock_unit;

  localparam int LSC = 3;
  localparam int FC  = 2;

  logic       clk;
  logic       resetIn;
  logic [4:0] rs1In, rs2In, exRdIn;
  logic       rs1UseIn, rs2UseIn, exRegWriteIn, exMemReadIn;
  logic       branchTakenIn, icacheReadyIn;
  logic       locker, pcHoldOut, bubbleOut, flushOut, ALUForwardCSLFromLock;
  logic [1:0] stateOut;
`ifdef LOCK_PERF_CNT_EN
  logic [31:0] stallCountOut, flushCountOut;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining cycles of each window and a miss flag.
  int      m_sl, m_fl;
  bit      m_miss;
  longint  m_stalls, m_flushes;

  pipe_lock_unit #(.LOAD_STALL_CYCLES(LSC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetIn(resetIn),
    .rs1In(rs1In), .rs2In(rs2In), .rs1UseIn(rs1UseIn), .rs2UseIn(rs2UseIn),
    .exRdIn(exRdIn), .exRegWriteIn(exRegWriteIn), .exMemReadIn(exMemReadIn),
    .branchTakenIn(branchTakenIn), .icacheReadyIn(icacheReadyIn),
    .locker(locker), .pcHoldOut(pcHoldOut), .bubbleOut(bubbleOut),
    .flushOut(flushOut), .ALUForwardCSLFromLock(ALUForwardCSLFromLock),
`ifdef LOCK_PERF_CNT_EN
    .stallCountOut(stallCountOut), .flushCountOut(flushCountOut),
`endif
    .stateOut(stateOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs_vec();
    return {locker, pcHoldOut, bubbleOut, flushOut, ALUForwardCSLFromLock, stateOut};
  endfunction

  task automatic set_idle();
    resetIn = 0; branchTakenIn = 0; icacheReadyIn = 1;
    exMemReadIn = 0; exRegWriteIn = 0; exRdIn = 0;
    rs1In = 0; rs2In = 0; rs1UseIn = 0; rs2UseIn = 0;
  endtask

  task automatic set_load_hz();
    set_idle();
    exMemReadIn = 1; exRegWriteIn = 1; exRdIn = 5; rs1In = 5; rs1UseIn = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    resetIn = 1;
    next_cycle();
    resetIn = 0;
  endtask

  // ---- model ----
  function automatic bit model_hz();
    bit m = (rs1UseIn && rs1In == exRdIn) || (rs2UseIn && rs2In == exRdIn);
    return exMemReadIn && exRegWriteIn && (exRdIn != 0) && m;
  endfunction

  function automatic bit model_fwd_cand();
    bit m = (rs1UseIn && rs1In == exRdIn) || (rs2UseIn && rs2In == exRdIn);
    return exRegWriteIn && !exMemReadIn && (exRdIn != 0) && m;
  endfunction

  function automatic logic [6:0] model_out();
    logic [1:0] st;
    st = (m_fl > 0) ? 2'd2 : (m_sl > 0) ? 2'd1 : m_miss ? 2'd3 : 2'd0;
    if (resetIn)                     return 7'b1011_0_00;
    if (branchTakenIn)               return {5'b1011_0, st};
    if (m_fl > 0)                    return {5'b1011_0, st};
    if (m_sl > 0)                    return {5'b0110_0, st};
    if (model_hz() || !icacheReadyIn) return {5'b0110_0, st};
    return {4'b1000, model_fwd_cand(), st};
  endfunction

  task automatic model_step();
    logic [6:0] o;
    o = model_out();
    if (resetIn) begin
      m_sl = 0; m_fl = 0; m_miss = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if (o[5]) m_stalls++;
    if (branchTakenIn) begin
      m_flushes++;
      m_fl = FC - 1; m_sl = 0; m_miss = 0;
    end else if (m_fl > 0) m_fl--;
    else if (m_sl > 0) m_sl--;
    else if (model_hz()) begin m_sl = LSC - 1; m_miss = 0; end
    else m_miss = !icacheReadyIn;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [6:0] obs;
    set_load_hz();
    icacheReadyIn = 0; branchTakenIn = 0; resetIn = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) set_idle();
      @(negedge clk);
      obs = obs_vec();
      n_cmp++;
      if (i < 2) begin
        if (obs !== 7'b1011_0_00) begin
          n_bad++; $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, 7'b1011_0_00);
        end
      end else if (obs !== 7'b1000_0_00) begin
        n_bad++; $display("FAIL reset_release: got %b want %b", obs, 7'b1000_0_00);
      end
      $display("tx reset cyc %0d obs %b", i, obs);
      next_cycle();
    end
  endtask

  task automatic test_load_stall();
    logic [6:0] exp_tab [4] = '{7'b0110_0_00, 7'b0110_0_01, 7'b0110_0_01, 7'b1000_0_00};
    logic [6:0] obs;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_load_hz(); else set_idle();
      @(negedge clk);
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_tab[i]) begin
        n_bad++; $display("FAIL load_stall cyc %0d: got %b want %b", i, obs, exp_tab[i]);
      end
      $display("tx load_stall cyc %0d obs %b", i, obs);
      next_cycle();
    end
  endtask

  task automatic test_alu_forward();
    logic [6:0] exp_tab [5] = '{7'b1000_1_00, 7'b1000_0_00, 7'b1011_0_00, 7'b1011_0_10, 7'b1000_1_00};
    logic [6:0] obs;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_idle();
      exRegWriteIn = 1; exRdIn = 7; rs2In = 7; rs2UseIn = 1;
      if (i == 1) begin exRdIn = 0; rs2In = 0; end
      if (i == 2) branchTakenIn = 1;
      @(negedge clk);
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_tab[i]) begin
        n_bad++; $display("FAIL alu_forward cyc %0d: got %b want %b", i, obs, exp_tab[i]);
      end
      $display("tx alu_forward cyc %0d obs %b", i, obs);
      next_cycle();
    end
  endtask

  task automatic test_miss();
    logic [6:0] exp_tab [6] = '{7'b0110_0_00, 7'b0110_0_11, 7'b0110_0_11, 7'b0110_0_11,
                                7'b1000_0_11, 7'b1000_0_00};
    logic [6:0] obs;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      icacheReadyIn = (i >= 4);
      @(negedge clk);
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_tab[i]) begin
        n_bad++; $display("FAIL miss cyc %0d: got %b want %b", i, obs, exp_tab[i]);
      end
      $display("tx miss cyc %0d obs %b", i, obs);
      next_cycle();
    end
  endtask

  task automatic test_branch_in_miss();
    logic [6:0] exp_tab [4] = '{7'b0110_0_00, 7'b1011_0_11, 7'b1011_0_10, 7'b1000_0_00};
    logic [6:0] obs;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      icacheReadyIn = (i >= 2);
      branchTakenIn = (i == 1);
      @(negedge clk);
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_tab[i]) begin
        n_bad++; $display("FAIL branch_in_miss cyc %0d: got %b want %b", i, obs, exp_tab[i]);
      end
`ifdef LOCK_PERF_CNT_EN
      if (i == 3) begin
        n_cmp++;
        if (stallCountOut !== 32'd1 || flushCountOut !== 32'd1) begin
          n_bad++; $display("FAIL branch_in_miss_perf: got stall %0d flush %0d want 1 1",
                            stallCountOut, flushCountOut);
        end
      end
`endif
      $display("tx branch_in_miss cyc %0d obs %b", i, obs);
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [6:0] exp_tab [4] = '{7'b0110_0_00, 7'b0110_0_01, 7'b1011_0_00, 7'b1000_0_00};
    logic [6:0] obs;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_load_hz(); else set_idle();
      resetIn = (i == 2);
      @(negedge clk);
      obs = obs_vec();
      n_cmp++;
      if (obs !== exp_tab[i]) begin
        n_bad++; $display("FAIL reset_mid_stall cyc %0d: got %b want %b", i, obs, exp_tab[i]);
      end
`ifdef LOCK_PERF_CNT_EN
      if (i == 3) begin
        n_cmp++;
        if (stallCountOut !== 32'd0 || flushCountOut !== 32'd0) begin
          n_bad++; $display("FAIL reset_mid_stall_perf: got stall %0d flush %0d want 0 0",
                            stallCountOut, flushCountOut);
        end
      end
`endif
      $display("tx reset_mid_stall cyc %0d obs %b", i, obs);
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [6:0] obs, expv;
    set_idle();
    resetIn = 1;
    model_step();
    next_cycle();
    for (int i = 0; i < 400; i++) begin
      resetIn       = ($urandom_range(0, 99) < 2);
      branchTakenIn = (m_fl == 0) && ($urandom_range(0, 99) < 10);
      icacheReadyIn = ($urandom_range(0, 99) < 80);
      exMemReadIn   = ($urandom_range(0, 99) < 30);
      exRegWriteIn  = ($urandom_range(0, 99) < 70);
      exRdIn        = 5'($urandom_range(0, 3));
      rs1In         = 5'($urandom_range(0, 3));
      rs2In         = 5'($urandom_range(0, 3));
      rs1UseIn      = 1'($urandom_range(0, 1));
      rs2UseIn      = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs  = obs_vec();
      expv = model_out();
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL random cyc %0d: got %b want %b", i, obs, expv);
      end
`ifdef LOCK_PERF_CNT_EN
      n_cmp++;
      if (stallCountOut !== 32'(m_stalls) || flushCountOut !== 32'(m_flushes)) begin
        n_bad++; $display("FAIL random_perf cyc %0d: got %0d/%0d want %0d/%0d",
                          i, stallCountOut, flushCountOut, m_stalls, m_flushes);
      end
`endif
      $display("tx random cyc %0d obs %b", i, obs);
      model_step();
      next_cycle();
    end
  endtask

  initial begin
    m_sl = 0; m_fl = 0; m_miss = 0; m_stalls = 0; m_flushes = 0;
    set_idle();
    #1;
    test_reset();
    test_load_stall();
    test_alu_forward();
    test_miss();
    test_branch_in_miss();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
